pulse_pacer: RTL

PULSE_PACER -- requirements
Module: pulse_pacer

---
 rtl/pulse_pacer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pulse_pacer.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_pacer
//  Purpose  : Accepts bursty single-cycle event requests, counts them, and
//             replays them as single-cycle pulses spaced exactly GAP cycles
//             apart (rising edge to rising edge). The output is meant to feed
//             a fast-to-slow pulse synchronizer, which needs that minimum
//             spacing to avoid merging pulses.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    GAP       minimum cycles between pulse_out rising edges (GAP >= 2)
//    CNT_W     width of the pending-event counter
//  Ports
//    clk        in   1      sole clock, rising edge
//    rst        in   1      synchronous active-high reset, dominates inputs
//    pulse_in   in   1      event request, one event per cycle sampled high
//    clr_ovf    in   1      clears the sticky overflow flag
//    pulse_out  out  1      paced single-cycle pulse, driven from a flop
//    pending    out  CNT_W  events accepted but not yet emitted
//    overflow   out  1      sticky, set when an event was dropped
//    busy       out  1      high while a sequence is running or events wait
// ============================================================================
module pulse_pacer #(
  parameter int unsigned GAP   = 6,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic             clr_ovf,
  output logic             pulse_out,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic             busy
);

  // Gap counter must hold GAP-2; one spare bit keeps it safe for GAP == 2.
  localparam int unsigned GAP_W = $clog2(GAP - 1) + 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIRE = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t           state_q,    state_d;
  logic [CNT_W-1:0] pending_q,  pending_d;
  logic [GAP_W-1:0] gap_cnt_q,  gap_cnt_d;
  logic             overflow_q, overflow_d;
  logic             pulse_q,    pulse_d;

  logic             take_event;  // transition into FIRE consumes one event
  logic             ovf_event;   // increment that found the counter full

  // --------------------------------------------------------------------------
  // Next-state logic for the pacing FSM and the gap counter
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    take_event = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pending_q != '0) begin
          state_d    = S_FIRE;
          take_event = 1'b1;
        end
      end

      S_FIRE: begin
        // The FIRE cycle itself is one cycle of the gap, and the cycle where
        // the counter reads zero is another, hence the load of GAP-2.
        state_d   = S_WAIT;
        gap_cnt_d = GAP_LOAD;
      end

      S_WAIT: begin
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
        end else if (pending_q != '0) begin
          state_d    = S_FIRE;
          take_event = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        gap_cnt_d = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Pending-event counter: saturating up, never below zero (take_event is
  // only raised when pending is non-zero). A simultaneous increment and
  // decrement cancel and cannot overflow.
  // --------------------------------------------------------------------------
  always_comb begin
    pending_d = pending_q;
    ovf_event = 1'b0;

    if (pulse_in && !take_event) begin
      if (pending_q == CNT_MAX) begin
        ovf_event = 1'b1;
      end else begin
        pending_d = pending_q + CNT_ONE;
      end
    end else if (!pulse_in && take_event) begin
      pending_d = pending_q - CNT_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Sticky overflow: a new drop wins over a coincident clear.
  // --------------------------------------------------------------------------
  always_comb begin
    overflow_d = ovf_event | (overflow_q & ~clr_ovf);
  end

  // The pulse gets its own flop, decoded from the next state, so the
  // synchronizer downstream sees a clean register output rather than a
  // state decode.
  always_comb begin
    pulse_d = (state_d == S_FIRE);
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pending_q  <= '0;
      gap_cnt_q  <= '0;
      overflow_q <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      gap_cnt_q  <= gap_cnt_d;
      overflow_q <= overflow_d;
      pulse_q    <= pulse_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign pulse_out = pulse_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q != S_IDLE) || (pending_q != '0);

endmodule
`default_nettype wire
